bch_seq_decoder: RTL and testbench
==================================

BCH_SEQ_DECODER -- requirements
Module: bch_seq_decoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, received codeword present.
REQ-004 SHALL have port in_ready, output, 1, decoder can accept a codeword.
REQ-005 SHALL have port rx_codeword, input, 15, received word; bit i = coefficient of x^i; [14:8] message, [7:0] parity.
REQ-006 SHALL have port out_valid, output, 1, result available.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-008 SHALL have port corrected_codeword, output, 15, rx_codeword XOR error_vector.
REQ-009 SHALL have port message_out, output, 7, corrected_codeword[14:8].
REQ-010 SHALL have port error_vector, output, 15, one bit set per corrected position.
REQ-011 SHALL have ports syndrome1 and syndrome3, output, 4 each, S1 = r(alpha), S3 = r(alpha^3).
REQ-012 SHALL have port num_errors, output, 2, corrected error count, 0..2.
REQ-013 SHALL have port uncorrectable, output, 1, decode failure flag.

Function
REQ-014 SHALL decode BCH(15,7), t=2, over GF(16) with primitive polynomial x^4+x+1 and generator x^8+x^7+x^6+x^4+1.
REQ-015 SHALL use FSM states IDLE, SYND, SOLVE, CHIEN, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL register rx_codeword and go IDLE->SYND on the edge where in_valid && in_ready.
REQ-017 SHALL in SYND run 15 cycles, one bit per cycle from bit 14 down to bit 0, using Horner updates S1 = S1*alpha + r_i and S3 = S3*alpha^3 + r_i, then go to SOLVE.
REQ-018 SHALL in SOLVE (1 cycle) compute the locator: S1=0,S3=0 -> no error; S1!=0, S3=S1^3 -> lambda1=S1, lambda2=0; S1!=0, S3!=S1^3 -> lambda1=S1, lambda2=(S3+S1^3)/S1; S1=0, S3!=0 -> uncorrectable.
REQ-019 SHALL in CHIEN run 15 cycles testing i=0..14 and set error_vector[i] when alpha^(2i) + lambda1*alpha^i + lambda2 = 0.
REQ-020 SHALL flag uncorrectable when the root count differs from the locator degree; error_vector is then forced to 0 and num_errors to 0.
REQ-021 SHALL assert out_valid in DONE exactly 32 cycles after the accepting edge, with all result outputs stable while out_valid is high.
REQ-022 SHALL hold DONE and all results while out_ready=0, and return to IDLE on the edge where out_valid && out_ready.
REQ-023 SHALL ignore in_valid outside IDLE; a codeword is never accepted in the DONE exit cycle.

Reset
REQ-024 SHALL on rst=0 immediately enter IDLE, clear all registers, and drive in_ready=0 during reset and 1 after it.
REQ-025 SHALL reset outputs to out_valid=0, corrected_codeword=0, message_out=0, error_vector=0, syndrome1=0, syndrome3=0, num_errors=0, uncorrectable=0.
REQ-026 SHALL on reset mid-decode discard the frame with no out_valid for it.

Configuration
REQ-027 SHALL, when macro BCH_DEC_STATS_EN is defined, add outputs cnt_corrected[15:0] and cnt_uncorr[15:0].
REQ-028 SHALL increment cnt_corrected at each result handshake with num_errors>0 and cnt_uncorr at each with uncorrectable=1; both counters saturate at 16'hFFFF and reset to 0.
REQ-029 SHALL, when BCH_DEC_STATS_EN is undefined, omit both ports and counters with no other behavioural change.

Verification
REQ-030 SHALL check: rx=15'b101110011100101 (codeword 15'b101010111100101 with bits 11 and 8 flipped) -> corrected 15'b101010111100101, message_out 7'b1010101, error_vector 15'b000100100000000, num_errors 2, uncorrectable 0.
REQ-031 SHALL check: rx=15'h0001 -> corrected 15'h0000, error_vector 15'h0001, num_errors 1.
REQ-032 SHALL check: rx=15'b101010111100101 (clean) -> syndromes 0, error_vector 0, num_errors 0, out_valid at cycle 32.
REQ-033 SHALL check: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored, frame delivered once when out_ready=1.
REQ-034 SHALL check: rst pulsed low at SYND cycle 7 -> all outputs at reset values immediately, no out_valid, next frame decodes correctly.
REQ-035 SHALL check: with BCH_DEC_STATS_EN, frames per REQ-030, REQ-031 and REQ-032 -> cnt_corrected=2, cnt_uncorr=0.

Source files
------------

// File: rtl/bch_seq_decoder.sv
// -----------------------------------------------------------------------------
// bch_seq_decoder
//   Bit-serial BCH(15,7), t=2 decoder over GF(16) (primitive poly x^4+x+1,
//   generator x^8+x^7+x^6+x^4+1). Each frame takes a fixed 32 cycles from the
//   accepting edge to out_valid:
//     SYND  : 15 cycles, Horner evaluation of S1 = r(a) and S3 = r(a^3)
//     SOLVE : 1 cycle, closed-form error locator for t=2
//     CHIEN : 15 root tests of X^2 + L1*X + L2 at X = a^i, plus 1 commit cycle
//     DONE  : results held until out_ready
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready high only in IDLE
//   rx_codeword[14:0]   received word, bit i = coefficient of x^i
//   out_valid/out_ready result handshake
//   corrected_codeword  rx XOR error_vector
//   message_out[6:0]    corrected_codeword[14:8]
//   error_vector[14:0]  one bit per corrected position
//   syndrome1/3[3:0]    S1, S3 of the received word
//   num_errors[1:0]     corrected error count
//   uncorrectable       decode failure flag
//
// Optional feature (macro BCH_DEC_STATS_EN):
//   cnt_corrected[15:0] handshakes delivering num_errors > 0 (saturating)
//   cnt_uncorr[15:0]    handshakes delivering uncorrectable = 1 (saturating)
// -----------------------------------------------------------------------------
module bch_seq_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [14:0] rx_codeword,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [14:0] corrected_codeword,
   output logic [6:0]  message_out,
   output logic [14:0] error_vector,
   output logic [3:0]  syndrome1,
   output logic [3:0]  syndrome3,
   output logic [1:0]  num_errors,
   output logic        uncorrectable
`ifdef BCH_DEC_STATS_EN
   ,
   output logic [15:0] cnt_corrected,
   output logic [15:0] cnt_uncorr
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYND,
      S_SOLVE,
      S_CHIEN,
      S_DONE
   } state_t;

   // ---------------------------------------------------------------- GF(16)
   // Multiply by alpha: shift left, reduce x^4 = x + 1.
   function automatic logic [3:0] gf_xa(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
   endfunction

   function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p;
      logic [3:0] x;
      p = 4'h0;
      x = a;
      for (int k = 0; k < 4; k++) begin
         if (b[k]) p = p ^ x;
         x = gf_xa(x);
      end
      return p;
   endfunction

   // Inverse by table: a^k -> a^(15-k). Zero maps to zero (never used).
   function automatic logic [3:0] gf_inv(input logic [3:0] a);
      logic [3:0] r;
      case (a)
         4'h1: r = 4'h1;
         4'h2: r = 4'h9;
         4'h4: r = 4'hD;
         4'h8: r = 4'hF;
         4'h3: r = 4'hE;
         4'h6: r = 4'h7;
         4'hC: r = 4'hA;
         4'hB: r = 4'h5;
         4'h5: r = 4'hB;
         4'hA: r = 4'hC;
         4'h7: r = 4'h6;
         4'hE: r = 4'h3;
         4'hF: r = 4'h8;
         4'hD: r = 4'h4;
         4'h9: r = 4'h2;
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------- state
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [14:0] r_rx;
   logic [14:0] r_shift;     // MSB-first copy consumed during SYND
   logic [3:0]  r_s1;
   logic [3:0]  r_s3;
   logic [3:0]  r_lam1;
   logic [3:0]  r_lam2;
   logic [1:0]  r_deg;
   logic        r_fail;      // S1=0, S3!=0: no valid locator exists
   logic [3:0]  r_alpha_i;   // a^i for current Chien position
   logic [3:0]  r_alpha_2i;  // a^(2i)
   logic [14:0] r_err;
   logic [1:0]  r_roots;

   logic        r_out_valid;
   logic [14:0] r_corr;
   logic [14:0] r_evec;
   logic [3:0]  r_syn1;
   logic [3:0]  r_syn3;
   logic [1:0]  r_nerr;
   logic        r_unc;

`ifdef BCH_DEC_STATS_EN
   logic [15:0] r_cnt_corr;
   logic [15:0] r_cnt_unc;
`endif

   // ---------------------------------------------------------------- datapath
   logic [3:0] w_s1_cube;
   logic [3:0] w_lam2;
   logic [3:0] w_chien_eval;
   logic       w_bad;
   logic [3:0] w_bit;

   assign w_bit        = {3'b000, r_shift[14]};
   assign w_s1_cube    = gf_mul(gf_mul(r_s1, r_s1), r_s1);
   assign w_lam2       = gf_mul(r_s3 ^ w_s1_cube, gf_inv(r_s1));
   assign w_chien_eval = r_alpha_2i ^ gf_mul(r_lam1, r_alpha_i) ^ r_lam2;
   // A locator whose root count disagrees with its degree means more than
   // two errors; the frame is reported uncorrectable and left untouched.
   assign w_bad        = r_fail | (r_roots != r_deg);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_rx        <= 15'd0;
         r_shift     <= 15'd0;
         r_s1        <= 4'h0;
         r_s3        <= 4'h0;
         r_lam1      <= 4'h0;
         r_lam2      <= 4'h0;
         r_deg       <= 2'd0;
         r_fail      <= 1'b0;
         r_alpha_i   <= 4'h1;
         r_alpha_2i  <= 4'h1;
         r_err       <= 15'd0;
         r_roots     <= 2'd0;
         r_out_valid <= 1'b0;
         r_corr      <= 15'd0;
         r_evec      <= 15'd0;
         r_syn1      <= 4'h0;
         r_syn3      <= 4'h0;
         r_nerr      <= 2'd0;
         r_unc       <= 1'b0;
`ifdef BCH_DEC_STATS_EN
         r_cnt_corr  <= 16'd0;
         r_cnt_unc   <= 16'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_rx    <= rx_codeword;
                  r_shift <= rx_codeword;
                  r_s1    <= 4'h0;
                  r_s3    <= 4'h0;
                  r_cnt   <= 4'd0;
                  r_state <= S_SYND;
               end
            end

            S_SYND: begin
               // Horner step, bit 14 first: S = S*a^k + r_i
               r_s1    <= gf_xa(r_s1) ^ w_bit;
               r_s3    <= gf_xa(gf_xa(gf_xa(r_s3))) ^ w_bit;
               r_shift <= {r_shift[13:0], 1'b0};
               if (r_cnt == 4'd14) begin
                  r_cnt   <= 4'd0;
                  r_state <= S_SOLVE;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end

            S_SOLVE: begin
               r_fail <= 1'b0;
               if (r_s1 == 4'h0) begin
                  r_lam1 <= 4'h0;
                  r_lam2 <= 4'h0;
                  r_deg  <= 2'd0;
                  r_fail <= (r_s3 != 4'h0);
               end else if (r_s3 == w_s1_cube) begin
                  r_lam1 <= r_s1;
                  r_lam2 <= 4'h0;
                  r_deg  <= 2'd1;
               end else begin
                  r_lam1 <= r_s1;
                  r_lam2 <= w_lam2;
                  r_deg  <= 2'd2;
               end
               r_alpha_i  <= 4'h1;
               r_alpha_2i <= 4'h1;
               r_err      <= 15'd0;
               r_roots    <= 2'd0;
               r_cnt      <= 4'd0;
               r_state    <= S_CHIEN;
            end

            S_CHIEN: begin
               if (r_cnt != 4'd15) begin
                  if (w_chien_eval == 4'h0) begin
                     r_err   <= r_err | (15'd1 << r_cnt);
                     r_roots <= r_roots + 2'd1;
                  end
                  r_alpha_i  <= gf_xa(r_alpha_i);
                  r_alpha_2i <= gf_xa(gf_xa(r_alpha_2i));
                  r_cnt      <= r_cnt + 4'd1;
               end else begin
                  // Commit cycle: all 15 positions have been tested.
                  r_unc       <= w_bad;
                  r_evec      <= w_bad ? 15'd0 : r_err;
                  r_nerr      <= w_bad ? 2'd0 : r_roots;
                  r_corr      <= w_bad ? r_rx : (r_rx ^ r_err);
                  r_syn1      <= r_s1;
                  r_syn3      <= r_s3;
                  r_out_valid <= 1'b1;
                  r_cnt       <= 4'd0;
                  r_state     <= S_DONE;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
`ifdef BCH_DEC_STATS_EN
                  if (r_nerr != 2'd0 && r_cnt_corr != 16'hFFFF)
                     r_cnt_corr <= r_cnt_corr + 16'd1;
                  if (r_unc && r_cnt_unc != 16'hFFFF)
                     r_cnt_unc <= r_cnt_unc + 16'd1;
`endif
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   // in_ready is held low while reset is asserted even though the state is IDLE.
   assign in_ready           = rst & (r_state == S_IDLE);
   assign out_valid          = r_out_valid;
   assign corrected_codeword = r_corr;
   assign message_out        = r_corr[14:8];
   assign error_vector       = r_evec;
   assign syndrome1          = r_syn1;
   assign syndrome3          = r_syn3;
   assign num_errors         = r_nerr;
   assign uncorrectable      = r_unc;
`ifdef BCH_DEC_STATS_EN
   assign cnt_corrected      = r_cnt_corr;
   assign cnt_uncorr         = r_cnt_unc;
`endif

endmodule

// File: tb/tb_bch_seq_decoder.sv
// -----------------------------------------------------------------------------
// tb_bch_seq_decoder
//   Self-checking bench for bch_seq_decoder: fixed vector table, hand-written
//   back-pressure and mid-decode reset sequences, and random codewords with
//   0..4 injected errors checked against a nearest-codeword reference model.
// -----------------------------------------------------------------------------
module tb_bch_seq_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [14:0] rx_codeword = 15'd0;
   logic        in_ready;
   logic        out_valid;
   logic [14:0] corrected_codeword;
   logic [6:0]  message_out;
   logic [14:0] error_vector;
   logic [3:0]  syndrome1;
   logic [3:0]  syndrome3;
   logic [1:0]  num_errors;
   logic        uncorrectable;
`ifdef BCH_DEC_STATS_EN
   logic [15:0] cnt_corrected;
   logic [15:0] cnt_uncorr;
`endif

   bch_seq_decoder dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .rx_codeword        (rx_codeword),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .corrected_codeword (corrected_codeword),
      .message_out        (message_out),
      .error_vector       (error_vector),
      .syndrome1          (syndrome1),
      .syndrome3          (syndrome3),
      .num_errors         (num_errors),
      .uncorrectable      (uncorrectable)
`ifdef BCH_DEC_STATS_EN
      ,
      .cnt_corrected      (cnt_corrected),
      .cnt_uncorr         (cnt_uncorr)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // ---------------------------------------------------------- reference model
   int          alog[15];
   logic [14:0] cwt[128];

   function automatic logic [14:0] encode(input logic [6:0] msg);
      logic [14:0] v;
      logic [14:0] g;
      g = 15'h01D1;
      v = {msg, 8'h00};
      for (int b = 14; b >= 8; b--)
         if (v[b]) v = v ^ (g << (b - 8));
      return {msg, v[7:0]};
   endfunction

   task automatic model(input logic [14:0] rx, output logic [14:0] corr, output logic [14:0] err,
                        output logic [1:0] n, output logic unc, output logic [3:0] s1,
                        output logic [3:0] s3);
      int best;
      int bi;
      int d;
      s1 = 4'h0;
      s3 = 4'h0;
      for (int i = 0; i < 15; i++)
         if (rx[i]) begin
            s1 = s1 ^ alog[i][3:0];
            s3 = s3 ^ alog[(3 * i) % 15][3:0];
         end
      best = 99;
      bi   = 0;
      for (int c = 0; c < 128; c++) begin
         d = $countones(rx ^ cwt[c]);
         if (d < best) begin
            best = d;
            bi   = c;
         end
      end
      if (best <= 2) begin
         corr = cwt[bi];
         err  = rx ^ cwt[bi];
         n    = best[1:0];
         unc  = 1'b0;
      end else begin
         corr = rx;
         err  = 15'd0;
         n    = 2'd0;
         unc  = 1'b1;
      end
   endtask

   // ---------------------------------------------------------- frame driver
   logic [14:0] g_corr;
   logic [6:0]  g_msg;
   logic [14:0] g_err;
   logic [3:0]  g_s1;
   logic [3:0]  g_s3;
   logic [1:0]  g_n;
   logic        g_unc;

   // Accepts rx, checks 32-cycle latency, captures results, holds for `hold`
   // cycles (optionally poking in_valid), then hands the result off.
   task automatic send_frame(input logic [14:0] rx, input int hold, input bit poke);
      int  guard;
      bit  early;
      bit  busy_ready;
      bit  unstable;
      bit  seen;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      in_valid    = 1'b1;
      rx_codeword = rx;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      rx_codeword = 15'($urandom);
      early      = 1'b0;
      busy_ready = 1'b0;
      for (int k = 1; k < 32; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) early = 1'b1;
         if (in_ready) busy_ready = 1'b1;
      end
      chk("no_early_valid", {31'd0, early}, 32'd0);
      chk("in_ready_low_busy", {31'd0, busy_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("valid_at_32", {31'd0, out_valid}, 32'd1);
      g_corr = corrected_codeword;
      g_msg  = message_out;
      g_err  = error_vector;
      g_s1   = syndrome1;
      g_s3   = syndrome3;
      g_n    = num_errors;
      g_unc  = uncorrectable;
      if (hold > 0) begin
         unstable = 1'b0;
         busy_ready = 1'b0;
         if (poke) begin
            in_valid    = 1'b1;
            rx_codeword = ~rx;
         end
         for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            if (!out_valid || corrected_codeword != g_corr || message_out != g_msg ||
                error_vector != g_err || syndrome1 != g_s1 || syndrome3 != g_s3 ||
                num_errors != g_n || uncorrectable != g_unc)
               unstable = 1'b1;
            if (in_ready) busy_ready = 1'b1;
         end
         chk("hold_stable", {31'd0, unstable}, 32'd0);
         chk("hold_in_ready_low", {31'd0, busy_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("valid_cleared", {31'd0, out_valid}, 32'd0);
      if (poke) begin
         // Still in IDLE means the word presented on the exit edge was ignored.
         chk("no_accept_on_exit", {31'd0, in_ready}, 32'd1);
         in_valid = 1'b0;
         seen = 1'b0;
         for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
         end
         chk("single_delivery", {31'd0, seen}, 32'd0);
      end
   endtask

   task automatic check_result(input string tag, input logic [14:0] corr, input logic [14:0] err,
                               input logic [1:0] n, input logic unc, input logic [3:0] s1,
                               input logic [3:0] s3);
      chk({tag, "_corr"}, {17'd0, g_corr}, {17'd0, corr});
      chk({tag, "_msg"},  {25'd0, g_msg},  {25'd0, corr[14:8]});
      chk({tag, "_err"},  {17'd0, g_err},  {17'd0, err});
      chk({tag, "_nerr"}, {30'd0, g_n},    {30'd0, n});
      chk({tag, "_unc"},  {31'd0, g_unc},  {31'd0, unc});
      chk({tag, "_s1"},   {28'd0, g_s1},   {28'd0, s1});
      chk({tag, "_s3"},   {28'd0, g_s3},   {28'd0, s3});
   endtask

   typedef struct {
      logic [14:0] rx;
      logic [14:0] corr;
      logic [14:0] err;
      logic [1:0]  n;
      logic        unc;
      logic [3:0]  s1;
      logic [3:0]  s3;
   } vec_t;

   vec_t tbl[7];

   // ---------------------------------------------------------- test
   initial begin
      logic [14:0] m_corr;
      logic [14:0] m_err;
      logic [1:0]  m_n;
      logic        m_unc;
      logic [3:0]  m_s1;
      logic [3:0]  m_s3;
      logic [14:0] e;
      logic [14:0] rxr;
      int          a;
      int          w;
      bit          seen;

      a = 1;
      for (int k = 0; k < 15; k++) begin
         alog[k] = a;
         a = a << 1;
         if (a & 16) a = a ^ 19;
      end
      for (int c = 0; c < 128; c++) cwt[c] = encode(7'(c));

      tbl[0] = '{15'h5CE5, 15'h55E5, 15'h0900, 2'd2, 1'b0, 4'hB, 4'h2};
      tbl[1] = '{15'h0001, 15'h0000, 15'h0001, 2'd1, 1'b0, 4'h1, 4'h1};
      tbl[2] = '{15'h55E5, 15'h55E5, 15'h0000, 2'd0, 1'b0, 4'h0, 4'h0};
      tbl[3] = '{15'h4001, 15'h0000, 15'h4001, 2'd2, 1'b0, 4'h8, 4'hE};
      tbl[4] = '{15'h7FFF, 15'h7FFF, 15'h0000, 2'd0, 1'b0, 4'h0, 4'h0};
      tbl[5] = '{15'h7FFE, 15'h7FFF, 15'h0001, 2'd1, 1'b0, 4'h1, 4'h1};
      tbl[6] = '{15'h4000, 15'h0000, 15'h4000, 2'd1, 1'b0, 4'h9, 4'hF};

      // Reset state
      #3;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_corr", {17'd0, corrected_codeword}, 32'd0);
      chk("rst_misc", {2'd0, message_out, error_vector, syndrome1, syndrome3, num_errors,
                       uncorrectable}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Fixed vectors
      for (int i = 0; i < 7; i++) begin
         send_frame(tbl[i].rx, i % 3, 1'b0);
         check_result("tbl", tbl[i].corr, tbl[i].err, tbl[i].n, tbl[i].unc, tbl[i].s1,
                      tbl[i].s3);
      end

      // Back-pressure: 5 cycles of out_ready=0 with in_valid poked
      send_frame(15'h5CE5, 5, 1'b1);
      check_result("bp", 15'h55E5, 15'h0900, 2'd2, 1'b0, 4'hB, 4'h2);

      // Random codewords with 0..4 errors
      for (int f = 0; f < 40; f++) begin
         w = int'($urandom_range(0, 4));
         e = 15'd0;
         while ($countones(e) < w) e[$urandom_range(0, 14)] = 1'b1;
         rxr = cwt[$urandom_range(0, 127)] ^ e;
         model(rxr, m_corr, m_err, m_n, m_unc, m_s1, m_s3);
         send_frame(rxr, int'($urandom_range(0, 3)), 1'b0);
         check_result("rnd", m_corr, m_err, m_n, m_unc, m_s1, m_s3);
      end

      // Reset during SYND
      @(negedge clk);
      in_valid    = 1'b1;
      rx_codeword = 15'h5CE5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_corr", {17'd0, corrected_codeword}, 32'd0);
      chk("midrst_misc", {2'd0, message_out, error_vector, syndrome1, syndrome3, num_errors,
                          uncorrectable}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_release_ready", {31'd0, in_ready}, 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_valid", {31'd0, seen}, 32'd0);

      for (int i = 0; i < 3; i++) begin
         send_frame(tbl[i].rx, 0, 1'b0);
         check_result("after_rst", tbl[i].corr, tbl[i].err, tbl[i].n, tbl[i].unc, tbl[i].s1,
                      tbl[i].s3);
      end
`ifdef BCH_DEC_STATS_EN
      chk("cnt_corrected", {16'd0, cnt_corrected}, 32'd2);
      chk("cnt_uncorr", {16'd0, cnt_uncorr}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
